// File: rtl/ysyx_22050710_ifu_pkg.sv
// Shared types and width helpers for the prefetching instruction fetch unit.
package ysyx_22050710_ifu_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } ifu_state_e;

  localparam logic [63:0] DEFAULT_RESET_PC   = 64'h8000_0000;
  localparam int          DEFAULT_INST_WIDTH = 32;
  localparam int          DEFAULT_DATA_WIDTH = 64;

  function automatic int lane_count(input int data_width, input int inst_width);
    return data_width / inst_width;
  endfunction

  function automatic int byte_off_w(input int width);
    return $clog2(width / 8);
  endfunction

  // A single-lane bus still gets a 1-bit index so the select logic stays legal.
  function automatic int lane_idx_w(input int data_width, input int inst_width);
    return (data_width > inst_width) ? $clog2(data_width / inst_width) : 1;
  endfunction

  localparam int LANE_COUNT = lane_count(DEFAULT_DATA_WIDTH, DEFAULT_INST_WIDTH);
  localparam int BYTE_OFF_W = byte_off_w(DEFAULT_DATA_WIDTH);
  localparam int LANE_IDX_W = lane_idx_w(DEFAULT_DATA_WIDTH, DEFAULT_INST_WIDTH);

endpackage

// File: rtl/ysyx_22050710_ifu_fifo.sv
// Prefetch queue holding {pc, inst} entries; flush wins over push and pop.
module ysyx_22050710_ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !i_flush;
  assign do_pop  = i_pop && (count != '0) && !i_flush;

  // NOTE: storage is deliberately not reset; the head is masked to zero while empty.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_valid = (count != '0);
  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  assign o_count = count;

endmodule

// File: rtl/ysyx_22050710_ifu_prefetch.sv
// Instruction fetch unit with prefetch queue and redirect flush.
// Optional perf counters: define YSYX_22050710_IFU_PREFETCH_PERF_EN.
module ysyx_22050710_ifu_prefetch
  import ysyx_22050710_ifu_pkg::*;
#(
  parameter int                    INST_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_redirect_valid,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [DATA_WIDTH-1:0] o_mem_req_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [INST_WIDTH-1:0] o_inst
`ifdef YSYX_22050710_IFU_PREFETCH_PERF_EN
  ,
  output logic [63:0]           o_perf_fetch_cnt,
  output logic [63:0]           o_perf_stall_cnt
`endif
);

  localparam int LANES      = lane_count(DATA_WIDTH, INST_WIDTH);
  localparam int INST_OFF_W = byte_off_w(INST_WIDTH);
  localparam int IDX_W      = lane_idx_w(DATA_WIDTH, INST_WIDTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W    = DATA_WIDTH + INST_WIDTH;

  localparam logic [DATA_WIDTH-1:0] INST_BYTES = DATA_WIDTH'(INST_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] ADDR_MASK  = ~DATA_WIDTH'((DATA_WIDTH / 8) - 1);

  ifu_state_e            state;
  ifu_state_e            state_nxt;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [IDX_W-1:0]      lane_idx;
  logic [INST_WIDTH-1:0] lane;
  logic                  handshake;
  logic                  push;
  logic                  pop;

  // Request valid is gated by reset so nothing is issued while held in reset.
  assign o_mem_req_valid = i_rst && (state == REQ) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign o_mem_req_addr  = fetch_pc & ADDR_MASK;
  assign handshake       = o_mem_req_valid && i_mem_req_ready;
  assign push            = (state == WAIT) && i_mem_rsp_valid && !i_redirect_valid;
  assign pop             = o_inst_valid && i_inst_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      REQ:     if (handshake) state_nxt = i_redirect_valid ? DROP : WAIT;
      WAIT: begin
        if (i_mem_rsp_valid)       state_nxt = REQ;
        else if (i_redirect_valid) state_nxt = DROP;
      end
      DROP:    if (i_mem_rsp_valid) state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (i_redirect_valid) fetch_pc <= i_redirect_pc;
      else if (push)        fetch_pc <= fetch_pc + INST_BYTES;
    end
  end

  assign lane_idx = IDX_W'((fetch_pc >> INST_OFF_W) & DATA_WIDTH'(LANES - 1));

  // NOTE: lane gets a default before the loop, so no latch is inferred.
  always_comb begin
    lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_idx == IDX_W'(i)) lane = i_mem_rsp_data[i*INST_WIDTH +: INST_WIDTH];
    end
  end

  ysyx_22050710_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_redirect_valid),
    .i_push      (push),
    .i_push_data ({fetch_pc, lane}),
    .i_pop       (pop),
    .o_valid     (o_inst_valid),
    .o_data      (fifo_head),
    .o_count     (fifo_count)
  );

  assign o_pc   = fifo_head[ENTRY_W-1:INST_WIDTH];
  assign o_inst = fifo_head[INST_WIDTH-1:0];

`ifdef YSYX_22050710_IFU_PREFETCH_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_perf_fetch_cnt <= '0;
      o_perf_stall_cnt <= '0;
    end else begin
      if (push && (o_perf_fetch_cnt != '1))          o_perf_fetch_cnt <= o_perf_fetch_cnt + 64'd1;
      if (!o_inst_valid && (o_perf_stall_cnt != '1)) o_perf_stall_cnt <= o_perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050710_ifu_prefetch.sv
// Self-checking bench: directed scenarios plus random traffic against a
// sequential-PC instruction stream model with a single-outstanding memory.
module tb_ysyx_22050710_ifu_prefetch;

  localparam logic [63:0] RST_PC     = 64'h8000_0000;
  localparam logic [63:0] FIXED_WORD = 64'hAAAA_BBBB_1111_2222;

  logic        i_clk;
  logic        i_rst;
  logic        i_redirect_valid;
  logic [63:0] i_redirect_pc;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [63:0] o_mem_req_addr;
  logic        i_mem_rsp_valid;
  logic [63:0] i_mem_rsp_data;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [63:0] o_pc;
  logic [31:0] o_inst;

  ysyx_22050710_ifu_prefetch #(
    .INST_WIDTH (32),
    .DATA_WIDTH (64),
    .RESET_PC   (64'h8000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_req_addr   (o_mem_req_addr),
    .i_mem_rsp_valid  (i_mem_rsp_valid),
    .i_mem_rsp_data   (i_mem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_pc             (o_pc),
    .o_inst           (o_inst)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Traffic knobs
  int rdy_pct = 100;
  int inst_pct = 0;
  int lat_min = 1;
  int lat_max = 1;
  logic use_fixed = 1'b1;
  logic [31:0] salt;

  // Memory model: one pending response at most
  logic        mem_busy = 1'b0;
  int          mem_delay = 0;
  logic [63:0] mem_addr = '0;
  int          hs_cnt = 0;
  int          rsp_cnt = 0;

  // Stream model
  logic [63:0] exp_req_pc = RST_PC;
  logic [63:0] exp_out_pc = RST_PC;
  logic        exp_empty = 1'b0;

  // Per-cycle samples
  logic        s_rst, s_req_valid, s_hs, s_rsp, s_inst_valid;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_inst;

  function automatic logic [63:0] word(input logic [63:0] addr);
    if (use_fixed) return FIXED_WORD;
    return {addr[31:0] ^ salt, addr[63:32] ^ addr[31:0] ^ ~salt};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] w;
    w = word(pc & ~64'h7);
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  task automatic tick(input logic redir, input logic [63:0] rpc);
    logic pop_s;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    i_mem_req_ready  = ($urandom_range(99) < rdy_pct);
    i_inst_ready     = ($urandom_range(99) < inst_pct);
    i_mem_rsp_valid  = mem_busy && (mem_delay == 0);
    i_mem_rsp_data   = i_mem_rsp_valid ? word(mem_addr) : {$urandom, $urandom};
    @(negedge i_clk);
    s_rst        = i_rst;
    s_req_valid  = o_mem_req_valid;
    s_addr       = o_mem_req_addr;
    s_hs         = o_mem_req_valid && i_mem_req_ready;
    s_rsp        = i_mem_rsp_valid;
    s_inst_valid = o_inst_valid;
    s_pc         = o_pc;
    s_inst       = o_inst;
    pop_s        = s_rst && o_inst_valid && i_inst_ready && !redir;
    if (s_rst) begin
      if (exp_empty) begin
        checks++;
        if (o_inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_empty: o_inst_valid=%b expected 0", o_inst_valid);
        end
      end
      if (s_hs) begin
        checks++;
        if (mem_busy) begin
          errors++;
          $display("FAIL one_outstanding: request addr=%h issued while a fetch is pending", s_addr);
        end
        if (!redir) begin
          checks++;
          if (s_addr !== (exp_req_pc & ~64'h7)) begin
            errors++;
            $display("FAIL req_addr: got %h expected %h", s_addr, exp_req_pc & ~64'h7);
          end
        end
      end
      if (pop_s) begin
        checks++;
        if (s_pc !== exp_out_pc || s_inst !== exp_inst(exp_out_pc)) begin
          errors++;
          $display("FAIL pop_entry: got {%h,%h} expected {%h,%h}",
                   s_pc, s_inst, exp_out_pc, exp_inst(exp_out_pc));
        end
      end
    end
    @(posedge i_clk);
    #1;
    exp_empty = 1'b0;
    if (!s_rst) begin
      exp_req_pc = RST_PC;
      exp_out_pc = RST_PC;
    end else if (redir) begin
      exp_req_pc = rpc;
      exp_out_pc = rpc;
      exp_empty  = 1'b1;
    end else begin
      if (s_hs)  exp_req_pc += 64'd4;
      if (pop_s) exp_out_pc += 64'd4;
    end
    if (s_rsp) begin
      mem_busy = 1'b0;
      rsp_cnt++;
    end else if (mem_busy && mem_delay != 0) begin
      mem_delay--;
    end
    if (s_hs) begin
      mem_busy  = 1'b1;
      mem_addr  = s_addr;
      mem_delay = int'($urandom_range(lat_max, lat_min)) - 1;
      hs_cnt++;
    end
  endtask

  task automatic do_reset();
    i_rst    = 1'b0;
    mem_busy = 1'b0;
    tick(1'b0, '0);
    tick(1'b0, '0);
    i_rst = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) tick(1'b0, '0);
    checks++;
    if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: req_valid=%b inst_valid=%b expected 0 0", s_req_valid, s_inst_valid);
    end
    checks++;
    if (s_pc !== 64'd0 || s_inst !== 32'd0) begin
      errors++;
      $display("FAIL reset_head: got {%h,%h} expected zeros", s_pc, s_inst);
    end
    i_rst = 1'b1;
  endtask

  task automatic test_first_fetch();
    tick(1'b0, '0);  // cycle 1
    checks++;
    if (s_req_valid !== 1'b1 || s_addr !== RST_PC) begin
      errors++;
      $display("FAIL first_req: valid=%b addr=%h expected 1 %h", s_req_valid, s_addr, RST_PC);
    end
    tick(1'b0, '0);  // cycle 2
    checks++;
    if (s_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL head_early: o_inst_valid=%b expected 0 at cycle 2", s_inst_valid);
    end
    tick(1'b0, '0);  // cycle 3
    checks++;
    if (s_inst_valid !== 1'b1 || s_pc !== RST_PC || s_inst !== 32'h1111_2222) begin
      errors++;
      $display("FAIL first_head: got %b {%h,%h} expected 1 {%h,11112222}", s_inst_valid, s_pc, s_inst, RST_PC);
    end
    tick(1'b0, '0);  // cycle 4
    inst_pct = 100;
    tick(1'b0, '0);  // cycle 5, pop
    checks++;
    if (s_req_valid !== 1'b1 || s_addr !== 64'h8000_0008) begin
      errors++;
      $display("FAIL lane_next_req: valid=%b addr=%h expected 1 0000000080000008", s_req_valid, s_addr);
    end
    inst_pct = 0;
    tick(1'b0, '0);  // cycle 6
    checks++;
    if (s_inst_valid !== 1'b1 || s_pc !== 64'h8000_0004 || s_inst !== 32'hAAAA_BBBB) begin
      errors++;
      $display("FAIL lane_select: got %b {%h,%h} expected 1 {0000000080000004,aaaabbbb}", s_inst_valid, s_pc, s_inst);
    end
  endtask

  task automatic test_queue_full();
    int hs0;
    do_reset();
    rdy_pct = 100; inst_pct = 0; lat_min = 1; lat_max = 1;
    hs0 = hs_cnt;
    repeat (20) tick(1'b0, '0);
    checks++;
    if (hs_cnt - hs0 != 4 || s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL queue_full: requests=%0d req_valid=%b expected 4 0", hs_cnt - hs0, s_req_valid);
    end
    inst_pct = 100;
    tick(1'b0, '0);
    checks++;
    if (s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_cycle: req_valid=%b expected 0", s_req_valid);
    end
    inst_pct = 0;
    tick(1'b0, '0);
    checks++;
    if (s_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: req_valid=%b expected 1", s_req_valid);
    end
    repeat (10) tick(1'b0, '0);
    checks++;
    if (hs_cnt - hs0 != 5) begin
      errors++;
      $display("FAIL full_refill: requests=%0d expected 5", hs_cnt - hs0);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rdy_pct = 100; inst_pct = 0; lat_min = 3; lat_max = 3; use_fixed = 1'b0;
    tick(1'b0, '0);               // request
    tick(1'b1, 64'h8000_0100);    // redirect while waiting
    tick(1'b0, '0);
    checks++;
    if (s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold: req_valid=%b expected 0", s_req_valid);
    end
    lat_min = 1; lat_max = 1;
    tick(1'b0, '0);               // stale response
    checks++;
    if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_stale: req_valid=%b inst_valid=%b expected 0 0", s_req_valid, s_inst_valid);
    end
    tick(1'b0, '0);
    checks++;
    if (s_req_valid !== 1'b1 || s_addr !== 64'h8000_0100 || s_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_wait_req: valid=%b addr=%h inst_valid=%b expected 1 0000000080000100 0",
               s_req_valid, s_addr, s_inst_valid);
    end
    inst_pct = 100;
    repeat (10) tick(1'b0, '0);
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    rdy_pct = 100; inst_pct = 0; lat_min = 2; lat_max = 2;
    tick(1'b0, '0);
    tick(1'b0, '0);
    lat_min = 1; lat_max = 1;
    tick(1'b1, 64'h8000_0200);    // coincides with the response
    tick(1'b0, '0);
    checks++;
    if (s_req_valid !== 1'b1 || s_addr !== 64'h8000_0200 || s_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_rsp_req: valid=%b addr=%h inst_valid=%b expected 1 0000000080000200 0",
               s_req_valid, s_addr, s_inst_valid);
    end
    inst_pct = 100;
    repeat (10) tick(1'b0, '0);
  endtask

  task automatic test_mid_reset();
    int   r0;
    logic reached;
    logic seen;
    do_reset();
    rdy_pct = 100; inst_pct = 0; lat_min = 4; lat_max = 4;
    r0 = rsp_cnt;
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, '0);
      if (rsp_cnt - r0 == 3 && mem_busy) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached || s_inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: reached=%b inst_valid=%b expected 1 1", reached, s_inst_valid);
    end
    i_rst = 1'b0;
    rdy_pct = 0;
    tick(1'b0, '0);
    tick(1'b0, '0);
    checks++;
    if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear: inst_valid=%b req_valid=%b expected 0 0", s_inst_valid, s_req_valid);
    end
    i_rst = 1'b1;
    for (int i = 0; i < 10 && mem_busy; i++) tick(1'b0, '0);
    rdy_pct = 100; lat_min = 1; lat_max = 1; inst_pct = 100;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1'b0, '0);
      if (s_hs) begin
        seen = 1'b1;
        checks++;
        if (s_addr !== RST_PC) begin
          errors++;
          $display("FAIL refetch_addr: got %h expected %h", s_addr, RST_PC);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL refetch_timeout: no request within 10 cycles, expected one");
    end
    repeat (20) tick(1'b0, '0);
  endtask

  task automatic test_random();
    logic [63:0] t;
    do_reset();
    rdy_pct = 75; inst_pct = 50; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) begin
        t = {$urandom, $urandom};
        if ($urandom_range(3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        tick(1'b1, t);
      end else begin
        tick(1'b0, '0);
      end
      if (i % 500 == 0) inst_pct = int'($urandom_range(100));
    end
  endtask

  initial begin
    salt             = $urandom;
    i_rst            = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_mem_req_ready  = 1'b0;
    i_mem_rsp_valid  = 1'b0;
    i_mem_rsp_data   = '0;
    i_inst_ready     = 1'b0;
    test_reset();
    test_first_fetch();
    test_queue_full();
    test_redirect_wait();
    test_redirect_rsp();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22050710_ifu_prefetch.md
# ysyx_22050710_ifu_prefetch

Parametrised instruction fetch unit with a small prefetch queue, sitting between the PC/branch logic and the decode stage. It issues aligned read requests to instruction memory over a valid/ready request channel, extracts the addressed instruction lane from each response and queues `{pc, inst}` pairs for decode behind a valid/ready handshake. A redirect input flushes the queue and any in-flight fetch, then restarts fetching at a new PC.

## Interface
- `INST_WIDTH`, 32: instruction width in bits; power of two.
- `DATA_WIDTH`, 64: memory data and PC width; a power-of-two multiple of `INST_WIDTH`.
- `RESET_PC`, 64'h8000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: prefetch queue entries; power of two, at least 2.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-low.
- `i_redirect_valid` in 1: flush the pipeline and restart fetching at `i_redirect_pc`.
- `i_redirect_pc` in DATA_WIDTH: redirect target.
- `o_mem_req_valid` out 1: read request valid.
- `i_mem_req_ready` in 1: memory accepts the request.
- `o_mem_req_addr` out DATA_WIDTH: fetch PC with the low log2(DATA_WIDTH/8) bits cleared.
- `i_mem_rsp_valid` in 1: read data valid. Always accepted; there is no backpressure on this channel.
- `i_mem_rsp_data` in DATA_WIDTH: read data.
- `o_inst_valid` out 1: queue head valid.
- `i_inst_ready` in 1: decode consumes the head.
- `o_pc` out DATA_WIDTH: PC of the head entry.
- `o_inst` out INST_WIDTH: instruction of the head entry.

## Operation
- State machine states: REQ, WAIT, DROP. Register `fetch_pc`.
- At most one request is outstanding at any time.
- **REQ**
  - `o_mem_req_valid` is 1 when the queue count is less than FIFO_DEPTH.
  - When the request handshake completes, go to WAIT.
- **WAIT**
  - On `i_mem_rsp_valid`, push `{fetch_pc, lane}` into the queue.
  - The lane is `i_mem_rsp_data[k*INST_WIDTH +: INST_WIDTH]`, where k is `fetch_pc[log2(DATA_WIDTH/8)-1 : log2(INST_WIDTH/8)]`.
  - Then set `fetch_pc += INST_WIDTH/8` (wraps modulo 2^DATA_WIDTH) and go to REQ.
- **DROP**
  - On `i_mem_rsp_valid`, discard the data and go to REQ.
- **Redirect (highest priority)**
  - Empties the queue; a pop in the same cycle is ignored.
  - Sets `fetch_pc <= i_redirect_pc`.
  - Next state:
    - In REQ without a handshake: stay in REQ.
    - In REQ with a handshake in the same cycle: go to DROP.
    - In WAIT without a response: go to DROP.
    - In WAIT with a response in the same cycle: drop the response, no push, go to REQ.
    - In DROP without a response: stay in DROP.
    - In DROP with a response in the same cycle: go to REQ.
- **Queue**
  - Synchronous FIFO.
  - Push and pop in the same cycle leave the count unchanged.
  - A push can never overflow: a request is issued only when count is less than FIFO_DEPTH, and the count only falls while a request is pending.
  - Pop happens when `o_inst_valid && i_inst_ready`.
- **Low PC bits**
  - `fetch_pc` bits below log2(INST_WIDTH/8) are carried unchanged.
  - No misalignment check is performed.

## Timing
- **Reset**, while `i_rst` is 0:
  - State REQ, `fetch_pc = RESET_PC`, queue empty.
  - `o_mem_req_valid = 0` and `o_inst_valid = 0`; `o_pc` and `o_inst` are 0.
- **Reset mid-operation**: abandons all state. A response that arrives later while the block is in REQ is ignored.
- **Output timing**:
  - `o_mem_req_valid` and `o_mem_req_addr` are combinational from state, count and `fetch_pc`.
  - `o_inst_valid`, `o_pc` and `o_inst` come from registered queue storage and pointers.
- **Latency**:
  - Request at cycle 1 after reset release.
  - With memory that is always ready and has 1-cycle latency, the response arrives at cycle 2 and the head is visible at cycle 3.
- **Throughput**: one instruction per 2 cycles at best.
- **Queue full**: `o_mem_req_valid` holds 0 until a pop occurs. Request valid rises in the cycle after the pop.
- **After redirect**:
  - `o_inst_valid = 0` from the next cycle onward.
  - The first new request is issued the next cycle from REQ, or after the stale response when in DROP.

## Configuration
- `YSYX_22050710_IFU_PREFETCH_PERF_EN`
- **Defined**, adds two outputs (clear on reset, saturate at all-ones):
  - `o_perf_fetch_cnt` out 64: increments on each queue push.
  - `o_perf_stall_cnt` out 64: increments each cycle `o_inst_valid == 0` with reset high.
- **Undefined**: these ports and their counters are absent. Functional behaviour is identical in both cases.

## Structure
- **Package `ysyx_22050710_ifu_pkg`**:
  - State enum: REQ, WAIT, DROP.
  - Default `RESET_PC`.
  - Helper localparams: lane count, byte-offset width, lane-index width.
- **Sub-module `ysyx_22050710_ifu_fifo`**:
  - Parametrised depth and width, storing `{pc, inst}`.
  - Provides count, push and pop.
  - Flush input with priority over push/pop.

## Test plan
- **Reset and first fetch**: Reset, release, memory always ready with 1-cycle latency returning 64'hAAAA_BBBB_1111_2222 → request addr 0x8000_0000 at cycle 1, head `{0x8000_0000, 0x1111_2222}` at cycle 3.
- **Lane select**: Sequential fetch of 0x8000_0004 with the same data → `o_inst = 0xAAAA_BBBB`, next request addr 0x8000_0008.
- **Queue full**: Hold `i_inst_ready = 0` → exactly 4 pushes, then `o_mem_req_valid` stays 0. One pop → one further request.
- **Redirect in WAIT**: Redirect to 0x8000_0100 while in WAIT, stale response 2 cycles later → stale response discarded, queue empty, next request addr 0x8000_0100.
- **Redirect with response in the same cycle**: Redirect coincident with a response → no push, next state REQ, request addr equals the redirect PC.
- **Mid-operation reset**: Drop `i_rst` with 3 queued entries and a request outstanding → `o_inst_valid = 0` next cycle. After release, the refetch starts at 0x8000_0000.
